// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin between pipeline and debug loader,
// with a bounded debug lock and one-cycle registered load/error responses.
module dmem_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [2:0]        cpu_len,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [2:0]        dbg_len,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [31:0]       dbg_wdata,
   input  logic              dbg_lock,
   output logic              cpu_gnt,
   output logic              dbg_gnt,
   output logic              cpu_rvalid,
   output logic              dbg_rvalid,
   output logic              cpu_err,
   output logic              dbg_err,
   output logic [31:0]       rdata,
   output logic              mem_ce,
   output logic              mem_read,
   output logic              mem_write,
   output logic [2:0]        mem_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_in,
   input  logic [31:0]       mem_out
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   typedef enum logic {ARB, LOCK} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prio_dbg_q, prio_dbg_d;
   logic             blk_q, blk_d;
   logic             cpu_rv_q, cpu_rv_d, dbg_rv_q, dbg_rv_d;
   logic             cpu_err_q, cpu_err_d, dbg_err_q, dbg_err_d;
   logic             cpu_legal, dbg_legal;

   assign cpu_legal = (cpu_len <= 3'd4);
   assign dbg_legal = (dbg_len <= 3'd4);

   // Grants are forced low during reset so the bus is quiet without a clock.
   always_comb begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
      if (rst_n) begin
         if (state_q == LOCK) begin
            dbg_gnt = dbg_req;
         end else if (cpu_req && dbg_req) begin
            cpu_gnt = ~prio_dbg_q;
            dbg_gnt = prio_dbg_q;
         end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prio_dbg_d = prio_dbg_q;
      blk_d      = blk_q;
      if (cpu_gnt) prio_dbg_d = 1'b1;
      if (dbg_gnt) prio_dbg_d = 1'b0;
      case (state_q)
         ARB: begin
            blk_d = blk_q & cpu_req & ~cpu_gnt;
            if (dbg_gnt && dbg_lock && (!blk_q || !cpu_req)) begin
               state_d = LOCK;
               cnt_d   = '0;
            end
         end
         LOCK: begin
            // Lock timeout hands the next tie to cpu and blocks immediate re-lock.
            if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
               state_d    = ARB;
               cnt_d      = '0;
               prio_dbg_d = 1'b0;
               blk_d      = 1'b1;
            end else if (!dbg_lock) begin
               state_d = ARB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      mem_ce    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_len   = '0;
      mem_addr  = '0;
      mem_in    = '0;
      if (cpu_gnt && cpu_legal) begin
         mem_ce    = 1'b1;
         mem_read  = ~cpu_we;
         mem_write = cpu_we;
         mem_len   = cpu_len;
         mem_addr  = cpu_addr;
         mem_in    = cpu_wdata;
      end else if (dbg_gnt && dbg_legal) begin
         mem_ce    = 1'b1;
         mem_read  = ~dbg_we;
         mem_write = dbg_we;
         mem_len   = dbg_len;
         mem_addr  = dbg_addr;
         mem_in    = dbg_wdata;
      end
   end

   assign cpu_rv_d  = cpu_gnt & cpu_legal & ~cpu_we;
   assign dbg_rv_d  = dbg_gnt & dbg_legal & ~dbg_we;
   assign cpu_err_d = cpu_gnt & ~cpu_legal;
   assign dbg_err_d = dbg_gnt & ~dbg_legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         cnt_q      <= '0;
         prio_dbg_q <= 1'b0;
         blk_q      <= 1'b0;
         cpu_rv_q   <= 1'b0;
         dbg_rv_q   <= 1'b0;
         cpu_err_q  <= 1'b0;
         dbg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prio_dbg_q <= prio_dbg_d;
         blk_q      <= blk_d;
         cpu_rv_q   <= cpu_rv_d;
         dbg_rv_q   <= dbg_rv_d;
         cpu_err_q  <= cpu_err_d;
         dbg_err_q  <= dbg_err_d;
      end
   end

   assign cpu_rvalid = cpu_rv_q;
   assign dbg_rvalid = dbg_rv_q;
   assign cpu_err    = cpu_err_q;
   assign dbg_err    = dbg_err_q;
   assign rdata      = (cpu_rv_q | dbg_rv_q) ? mem_out : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory behind the DUT, an ownership/response model
// compared every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

   localparam int ADDR_W   = 5;
   localparam int LOCK_MAX = 16;
   localparam int MSZ      = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
   logic [2:0]        cpu_len, dbg_len;
   logic [ADDR_W-1:0] cpu_addr, dbg_addr;
   logic [31:0]       cpu_wdata, dbg_wdata;
   logic              cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err, dbg_err;
   logic [31:0]       rdata;
   logic              mem_ce, mem_read, mem_write;
   logic [2:0]        mem_len;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_in;
   logic [31:0]       mem_out = 32'd0;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_len(cpu_len), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_len(dbg_len), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock),
      .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt), .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid),
      .cpu_err(cpu_err), .dbg_err(dbg_err), .rdata(rdata),
      .mem_ce(mem_ce), .mem_read(mem_read), .mem_write(mem_write),
      .mem_len(mem_len), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ld(input logic [7:0] m [MSZ], input logic [ADDR_W-1:0] a,
                                      input logic [2:0] len);
      logic [31:0]       w;
      logic [ADDR_W-1:0] ai;
      w = '0;
      for (int i = 0; i < 4; i++) begin
         ai = a + ADDR_W'(i);
         w[8*i +: 8] = m[ai];
      end
      case (len)
         3'd0:    return {{24{w[7]}}, w[7:0]};
         3'd1:    return {{16{w[15]}}, w[15:0]};
         3'd2:    return w;
         3'd3:    return {24'd0, w[7:0]};
         default: return {16'd0, w[15:0]};
      endcase
   endfunction

   function automatic int nbytes(input logic [2:0] len);
      if (len == 3'd2) return 4;
      if (len == 3'd1 || len == 3'd4) return 2;
      return 1;
   endfunction

   // Memory the DUT talks to: registered read, write at the command edge.
   logic [7:0] dmem [MSZ];
   initial begin
      for (int i = 0; i < MSZ; i++) dmem[i] = 8'(i);
      forever begin
         @(posedge clk);
         if (mem_ce && mem_read) mem_out <= ld(dmem, mem_addr, mem_len);
         if (mem_ce && mem_write)
            for (int i = 0; i < nbytes(mem_len); i++)
               dmem[mem_addr + ADDR_W'(i)] = mem_in[8*i +: 8];
      end
   end

   // Behavioural model of ownership and responses.
   logic [7:0] shadow [MSZ];
   bit         m_locked, m_cpu_turn, m_blocked;
   int         m_lock_cyc;
   bit         p_cpu_rv, p_dbg_rv, p_cpu_err, p_dbg_err;
   logic [31:0] p_data;

   function automatic logic [1:0] exp_gnt();
      if (!rst_n) return 2'b00;
      if (m_locked) return {1'b0, dbg_req};
      if (cpu_req && dbg_req) return m_cpu_turn ? 2'b10 : 2'b01;
      return {cpu_req, dbg_req};
   endfunction

   function automatic logic [42:0] exp_mem();
      logic [1:0] g;
      g = exp_gnt();
      if (g[1] && cpu_len <= 3'd4) return {1'b1, ~cpu_we, cpu_we, cpu_len, cpu_addr, cpu_wdata};
      if (g[0] && dbg_len <= 3'd4) return {1'b1, ~dbg_we, dbg_we, dbg_len, dbg_addr, dbg_wdata};
      return '0;
   endfunction

   task automatic model_step();
      logic [1:0]        g;
      logic              we, legal;
      logic [2:0]        len;
      logic [ADDR_W-1:0] a;
      logic [31:0]       wd;
      g     = exp_gnt();
      we    = g[1] ? cpu_we : dbg_we;
      len   = g[1] ? cpu_len : dbg_len;
      a     = g[1] ? cpu_addr : dbg_addr;
      wd    = g[1] ? cpu_wdata : dbg_wdata;
      legal = (len <= 3'd4);
      p_cpu_rv  = g[1] && legal && !we;
      p_dbg_rv  = g[0] && legal && !we;
      p_cpu_err = g[1] && !legal;
      p_dbg_err = g[0] && !legal;
      if (g != 2'b00 && legal) begin
         if (!we) p_data = ld(shadow, a, len);
         else for (int i = 0; i < nbytes(len); i++) shadow[a + ADDR_W'(i)] = wd[8*i +: 8];
      end
      if (m_locked) begin
         m_lock_cyc++;
         if (g[0]) m_cpu_turn = 1;
         if (m_lock_cyc == LOCK_MAX) begin
            m_locked = 0; m_lock_cyc = 0; m_cpu_turn = 1; m_blocked = 1;
         end else if (!dbg_lock) begin
            m_locked = 0; m_lock_cyc = 0;
         end
      end else begin
         if (g[1]) m_cpu_turn = 0;
         if (g[0]) m_cpu_turn = 1;
         if (g[0] && dbg_lock && (!m_blocked || !cpu_req)) m_locked = 1;
         if (g[1] || !cpu_req) m_blocked = 0;
      end
   endtask

   initial begin
      for (int i = 0; i < MSZ; i++) shadow[i] = 8'(i);
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_locked = 0; m_lock_cyc = 0; m_cpu_turn = 1; m_blocked = 0;
            p_cpu_rv = 0; p_dbg_rv = 0; p_cpu_err = 0; p_dbg_err = 0; p_data = '0;
         end else begin
            model_step();
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("gnt", {cpu_gnt, dbg_gnt}, exp_gnt());
      check("resp", {cpu_rvalid, dbg_rvalid, cpu_err, dbg_err},
            rst_n ? {p_cpu_rv, p_dbg_rv, p_cpu_err, p_dbg_err} : 4'b0);
      check("rdata", rdata, (rst_n && (p_cpu_rv || p_dbg_rv)) ? p_data : 32'd0);
      check("memcmd", {mem_ce, mem_read, mem_write, mem_len, mem_addr, mem_in}, exp_mem());
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 0; cpu_we = 0; cpu_len = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_len = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
   endtask

   task automatic drv_cpu(input logic we, input logic [2:0] len, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd);
      cpu_req = 1; cpu_we = we; cpu_len = len; cpu_addr = a; cpu_wdata = wd;
   endtask

   task automatic drv_dbg(input logic we, input logic [2:0] len, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input logic lock);
      dbg_req = 1; dbg_we = we; dbg_len = len; dbg_addr = a; dbg_wdata = wd; dbg_lock = lock;
   endtask

   initial begin
      int  starve;
      bit  got;
      idle();
      repeat (3) @(posedge clk);
      #1;
      check("reset gnt", {cpu_gnt, dbg_gnt}, 0);
      check("reset rdata", rdata, 0);
      rst_n = 1;

      // Word load from preloaded memory.
      drv_cpu(0, 3'd2, 5'h04, 32'd0);
      #4 check("t1 cpu_gnt", cpu_gnt, 1);
      step(); idle();
      #4 check("t1 cpu_rvalid", cpu_rvalid, 1);
      check("t1 rdata", rdata, 32'h07060504);
      step();

      // Round-robin alternation on continuous contention.
      drv_dbg(0, 3'd2, 5'h10, 32'd0, 0);
      step();
      for (int k = 0; k < 4; k++) begin
         drv_cpu(0, 3'd2, ADDR_W'(4 * k), 32'd0);
         drv_dbg(0, 3'd2, ADDR_W'(16 + 4 * k), 32'd0, 0);
         #4 check("t2 cpu_gnt", cpu_gnt, (k % 2 == 0) ? 1 : 0);
         check("t2 dbg_gnt", dbg_gnt, (k % 2 == 1) ? 1 : 0);
         step();
      end
      idle(); step();

      // Debug lock bounded to LOCK_MAX cycles of cpu starvation.
      drv_dbg(0, 3'd2, 5'h08, 32'd0, 1);
      step();
      drv_cpu(0, 3'd2, 5'h0C, 32'd0);
      starve = 0;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         #4;
         if (cpu_gnt) got = 1;
         else starve++;
         step();
      end
      check("t3 cpu released", got, 1);
      check("t3 starve cycles", starve, 16);
      #4 check("t3 dbg wins next", dbg_gnt, 1);
      step();
      #4 check("t3 relocked", cpu_gnt, 0);
      step();
      dbg_req = 0; dbg_lock = 0;
      #4 check("t3 unlock cycle", cpu_gnt, 0);
      step();
      #4 check("t3 after unlock", cpu_gnt, 1);
      step(); idle(); step();

      // Byte store then zero-/sign-extended byte loads, back to back.
      drv_cpu(1, 3'd0, 5'h03, 32'h000000AB);
      step();
      drv_cpu(0, 3'd3, 5'h03, 32'd0);
      step();
      drv_cpu(1, 3'd0, 5'h09, 32'h000000F0);
      #4 check("t4 lbu rdata", rdata, 32'h000000AB);
      step();
      drv_cpu(0, 3'd0, 5'h09, 32'd0);
      step(); idle();
      #4 check("t4 lb rdata", rdata, 32'hFFFFFFF0);
      step();

      // Illegal length from debug.
      drv_dbg(0, 3'd6, 5'h00, 32'd0, 0);
      #4 check("t5 dbg_gnt", dbg_gnt, 1);
      check("t5 mem_ce", mem_ce, 0);
      step(); idle();
      #4 check("t5 dbg_err", dbg_err, 1);
      check("t5 dbg_rvalid", dbg_rvalid, 0);
      step();
      #4 check("t5 err clears", dbg_err, 0);
      step();

      // Reset mid-cycle while a load response is pending.
      drv_cpu(0, 3'd2, 5'h00, 32'd0);
      #4 check("t6 cpu_gnt", cpu_gnt, 1);
      step();
      drv_dbg(0, 3'd2, 5'h10, 32'd0, 0);
      #2 rst_n = 0;
      #1 check("t6 rvalid killed", cpu_rvalid, 0);
      check("t6 rdata zero", rdata, 0);
      check("t6 gnt forced", {cpu_gnt, dbg_gnt}, 0);
      check("t6 mem_ce", mem_ce, 0);
      step();
      rst_n = 1;
      #4 check("t6 no late rvalid", cpu_rvalid, 0);
      check("t6 tie to cpu", {cpu_gnt, dbg_gnt}, 2'b10);
      step(); idle();
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
